// File: rtl/axi4lite_mem_ctrl_if.sv
// AXI4-Lite slave-side bus bundle for axi4lite_mem_ctrl.
// The master modport is the interconnect/bench side, slave is the controller.
interface axi4lite_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4lite_mem_ctrl.sv
// AXI4-Lite slave front-end for the register-bank mem interface.
// One transaction at a time; ties between a pending write and read are
// broken round-robin (the side not served last wins).
// Optional macro AXI_SLVERR_EN: out-of-range accesses answer SLVERR
// instead of OKAY.
module axi4lite_mem_ctrl #(
  parameter int REGISTER_N     = 16,
  parameter int REG_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH     = 8,
  localparam int RA = $clog2(REGISTER_N),
  localparam int WA = ADDR_WIDTH - 2,
  localparam int SW = REG_DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  axi4lite_mem_ctrl_if.slave        s_axi,
  output logic                      mem_wrSelect,
  output logic [RA-1:0]             mem_wrAddr,
  output logic [REG_DATA_WIDTH-1:0] mem_wrdin,
  output logic [SW-1:0]             mem_wrByteStrobe,
  output logic                      mem_rdSelect,
  output logic [RA-1:0]             mem_rdAddr,
  output logic                      mem_rdStrobe,
  input  logic [REG_DATA_WIDTH-1:0] mem_rddout
);

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_SLVERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b10;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP} state_e;

  state_e                    state_q, state_d;
  logic                      rd_first_q;   // 1: a write was served last, read wins a tie
  logic [WA-1:0]             wr_addr_q, rd_addr_q;
  logic [REG_DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [SW-1:0]             wstrb_q;
  logic [1:0]                bresp_q, rresp_q;
  logic                      grant_wr, grant_rd;
  logic                      wr_in_range, rd_in_range;

  // Full word address is kept so out-of-range words are not aliased into the bank.
  assign wr_in_range = {1'b0, wr_addr_q} < (WA+1)'(REGISTER_N);
  assign rd_in_range = {1'b0, rd_addr_q} < (WA+1)'(REGISTER_N);

  // Arbitration: only in IDLE and never while reset is held.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (s_axi.awvalid && s_axi.wvalid && (!s_axi.arvalid || !rd_first_q))
        grant_wr = 1'b1;
      else if (s_axi.arvalid)
        grant_rd = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_wr) state_d = WRITE;
               else if (grant_rd) state_d = READ;
      WRITE:   state_d = WRESP;
      WRESP:   if (s_axi.bready) state_d = IDLE;
      READ:    state_d = RRESP;
      RRESP:   if (s_axi.rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state plus the registered transaction fields.
  always_comb begin
    s_axi.awready    = grant_wr;
    s_axi.wready     = grant_wr;
    s_axi.arready    = grant_rd;
    s_axi.bvalid     = (state_q == WRESP);
    s_axi.bresp      = bresp_q;
    s_axi.rvalid     = (state_q == RRESP);
    s_axi.rdata      = rdata_q;
    s_axi.rresp      = rresp_q;
    mem_wrSelect     = (state_q == WRITE) && wr_in_range;
    mem_wrByteStrobe = mem_wrSelect ? wstrb_q : '0;
    mem_rdSelect     = (state_q == READ) && rd_in_range;
    mem_rdStrobe     = mem_rdSelect;
    mem_wrAddr       = wr_addr_q[RA-1:0];
    mem_wrdin        = wdata_q;
    mem_rdAddr       = rd_addr_q[RA-1:0];
  end

  // Capture on grant, resolve response/read data in the single access cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_first_q <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      bresp_q    <= RESP_OKAY;
      rresp_q    <= RESP_OKAY;
    end else begin
      if (grant_wr) begin
        wr_addr_q  <= s_axi.awaddr[ADDR_WIDTH-1:2];
        wdata_q    <= s_axi.wdata;
        wstrb_q    <= s_axi.wstrb;
        rd_first_q <= 1'b1;
      end
      if (grant_rd) begin
        rd_addr_q  <= s_axi.araddr[ADDR_WIDTH-1:2];
        rd_first_q <= 1'b0;
      end
      if (state_q == WRITE)
        bresp_q <= wr_in_range ? RESP_OKAY : RESP_OOR;
      if (state_q == READ) begin
        rdata_q <= rd_in_range ? mem_rddout : '0;
        rresp_q <= rd_in_range ? RESP_OKAY : RESP_OOR;
      end
    end
  end

endmodule
